// File: rtl/ksa16_rr_arbiter.sv
// Round-robin arbiter sharing one 16-bit Kogge-Stone adder among NUM_REQ requesters.
// Two stages: operand register -> adder -> result register with requester ID.

module kogge_stone_16b (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [16:0] s
);
  // g[l]/p[l] hold group generate/propagate spanning 2**l bits ending at each position
  logic [4:0][15:0] g;
  logic [3:0][15:0] p;

  assign g[0] = a & b;
  assign p[0] = a ^ b;

  for (genvar l = 0; l < 4; l++) begin : g_lvl
    localparam int D = 1 << l;
    for (genvar i = 0; i < 16; i++) begin : g_bit
      if (i >= D) begin : g_op
        assign g[l+1][i] = g[l][i] | (p[l][i] & g[l][i-D]);
        if (l < 3) begin : g_p
          assign p[l+1][i] = p[l][i] & p[l][i-D];
        end
      end else begin : g_pass
        assign g[l+1][i] = g[l][i];
        if (l < 3) begin : g_p
          assign p[l+1][i] = p[l][i];
        end
      end
    end
  end

  // No carry-in: carry into bit i is the prefix generate of bits [i-1:0]
  assign s = {g[4][15], p[0] ^ {g[4][14:0], 1'b0}};
endmodule

module ksa16_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*16-1:0]  req_x,
  input  logic [NUM_REQ*16-1:0]  req_y,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [16:0]            rsp_sum,
  output logic [ID_W-1:0]        rsp_id
);
  logic [NUM_REQ-1:0][15:0] xv, yv;
  logic                     s1_valid;
  logic [15:0]              s1_x, s1_y;
  logic [ID_W-1:0]          s1_id, rr_ptr, gnt_id, idx;
  logic                     gnt_any, s1_free, s2_free;
  logic [16:0]              sum;
  int                       t;

  assign xv = req_x;
  assign yv = req_y;

  assign s2_free = !rsp_valid || rsp_ready;
  assign s1_free = !s1_valid || s2_free;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    gnt_any   = 1'b0;
    gnt_id    = '0;
    idx       = '0;
    t         = 0;
    req_ready = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      t = int'(rr_ptr) + k;
      if (t >= NUM_REQ) t = t - NUM_REQ;
      idx = ID_W'(t);
      if (!gnt_any && req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = idx;
      end
    end
    if (rst || !s1_free) gnt_any = 1'b0;
    if (gnt_any) req_ready[gnt_id] = 1'b1;
  end

  kogge_stone_16b u_add (.a(s1_x), .b(s1_y), .s(sum));

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_x      <= '0;
      s1_y      <= '0;
      s1_id     <= '0;
      rr_ptr    <= '0;
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_id    <= '0;
    end else begin
      if (s1_valid && s2_free) begin
        rsp_valid <= 1'b1;
        rsp_sum   <= sum;
        rsp_id    <= s1_id;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
      // A grant already implies s1 is free this cycle
      if (gnt_any) begin
        s1_valid <= 1'b1;
        s1_x     <= xv[gnt_id];
        s1_y     <= yv[gnt_id];
        s1_id    <= gnt_id;
        rr_ptr   <= (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
      end else if (s2_free) begin
        s1_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ksa16_rr_arbiter.sv
// Randomized/directed bench for ksa16_rr_arbiter against a transaction-level queue model.
module tb_ksa16_rr_arbiter;
  localparam int N = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [N-1:0]        vv;
  logic [N-1:0]        req_ready;
  logic [N-1:0][15:0]  vx, vy;
  logic                rsp_valid, rsp_ready;
  logic [16:0]         rsp_sum;
  logic [1:0]          rsp_id;

  always #5 clk = ~clk;

  ksa16_rr_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .rst(rst), .req_valid(vv), .req_ready(req_ready),
    .req_x(vx), .req_y(vy), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_id(rsp_id)
  );

  // Model: in-flight results in acceptance order; a result is visible two cycles after its accept
  typedef struct { int sum; int id; int acc; } ent_t;
  ent_t q[$];
  int   rr, cyc, tests, fails;

  function automatic bit m_vis();
    return (q.size() > 0) && (cyc >= q[0].acc + 2);
  endfunction

  function automatic int m_grant();
    if (rst) return -1;
    if (!(q.size() < 2 || (rsp_ready && m_vis()))) return -1;
    for (int k = 0; k < N; k++)
      if (vv[(rr + k) % N]) return (rr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] m_ready();
    logic [N-1:0] r;
    int g;
    r = '0;
    g = m_grant();
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  function automatic logic [18:0] m_rsp();
    return {2'(q[0].id), 17'(q[0].sum)};
  endfunction

  task automatic step();
    int g;
    bit pop;
    g   = m_grant();
    pop = m_vis() && rsp_ready;
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
      rr = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (g >= 0) begin
        q.push_back('{int'(vx[g]) + int'(vy[g]), g, cyc});
        rr = (g + 1) % N;
        vv[g] = 1'b0;
      end
    end
    cyc++;
  endtask

  task automatic drain();
    rst = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (q.size() == 0 && vv == '0) break;
      @(negedge clk);
      step();
    end
    tests++;
    if (q.size() != 0 || vv != '0) begin
      fails++;
      $display("FAIL drain: %0d results still in flight, want 0", q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rsp_ready = 1'b0; vv = '0; vx = '0; vy = '0;
    @(negedge clk);
    step();
    vv[2] = 1'b1; vx[2] = 16'h0101; vy[2] = 16'h0202;
    @(negedge clk);
    tests++;
    if (req_ready !== '0) begin fails++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    tests++;
    if ({rsp_valid, rsp_id, rsp_sum} !== 20'h0) begin
      fails++; $display("FAIL reset_outputs: got v=%b id=%0d sum=%h want all 0", rsp_valid, rsp_id, rsp_sum);
    end
    step();
    rst = 1'b0;
    drain();
  endtask

  task automatic test_single_add();
    drain();
    vv[1] = 1'b1; vx[1] = 16'h1234; vy[1] = 16'h0FFF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      tests++;
      if (req_ready !== m_ready()) begin fails++; $display("FAIL single_ready: got %b want %b", req_ready, m_ready()); end
      tests++;
      if (rsp_valid !== m_vis()) begin fails++; $display("FAIL single_valid: got %b want %b", rsp_valid, m_vis()); end
      if (k == 2) begin
        tests++;
        if ({rsp_valid, rsp_id, rsp_sum} !== {1'b1, 2'd1, 17'h02233}) begin
          fails++; $display("FAIL single_result: got v=%b id=%0d sum=%h want v=1 id=1 sum=02233", rsp_valid, rsp_id, rsp_sum);
        end
      end
      step();
    end
  endtask

  task automatic test_carry();
    logic [16:0] want [2];
    int n;
    want[0] = 17'h10000; want[1] = 17'h1FFFE; n = 0;
    drain();
    vv[2] = 1'b1; vx[2] = 16'hFFFF; vy[2] = 16'h0001;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (m_vis()) begin
        tests++;
        if (n < 2 && rsp_sum !== want[n]) begin
          fails++; $display("FAIL carry_sum%0d: got %h want %h", n, rsp_sum, want[n]);
        end
        n++;
      end
      tests++;
      if (rsp_valid !== m_vis()) begin fails++; $display("FAIL carry_valid: got %b want %b", rsp_valid, m_vis()); end
      step();
      if (k == 0) begin vv[2] = 1'b1; vx[2] = 16'hFFFF; vy[2] = 16'hFFFF; end
    end
    tests++;
    if (n != 2) begin fails++; $display("FAIL carry_count: got %0d results want 2", n); end
  endtask

  task automatic test_fairness();
    drain();
    for (int i = 0; i < N; i++) begin vv[i] = 1'b1; vx[i] = 16'(i * 16'h1111); vy[i] = 16'(16'h0F00 + i); end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      tests++;
      if (req_ready !== m_ready() || $countones(req_ready) != 1) begin
        fails++; $display("FAIL fair_grant: got %b want %b", req_ready, m_ready());
      end
      tests++;
      if (rsp_valid !== m_vis()) begin fails++; $display("FAIL fair_valid: got %b want %b", rsp_valid, m_vis()); end
      if (m_vis()) begin
        tests++;
        if ({rsp_id, rsp_sum} !== m_rsp()) begin fails++; $display("FAIL fair_rsp: got %h want %h", {rsp_id, rsp_sum}, m_rsp()); end
      end
      step();
      for (int i = 0; i < N; i++)
        if (!vv[i]) begin vv[i] = 1'b1; vx[i] = 16'($urandom); vy[i] = 16'($urandom); end
    end
    vv = '0;
  endtask

  task automatic test_backpressure();
    logic [18:0] held;
    drain();
    vv[2:0] = 3'b111;
    for (int i = 0; i < 3; i++) begin vx[i] = 16'($urandom); vy[i] = 16'($urandom); end
    held = '0;
    for (int k = 0; k < 16; k++) begin
      if (k == 3) begin rsp_ready = 1'b0; vv[3] = 1'b1; vx[3] = 16'hA5A5; vy[3] = 16'h5A5A; end
      if (k == 8) rsp_ready = 1'b1;
      @(negedge clk);
      tests++;
      if (req_ready !== m_ready()) begin fails++; $display("FAIL bp_ready: got %b want %b", req_ready, m_ready()); end
      tests++;
      if (rsp_valid !== m_vis()) begin fails++; $display("FAIL bp_valid: got %b want %b", rsp_valid, m_vis()); end
      if (m_vis()) begin
        tests++;
        if ({rsp_id, rsp_sum} !== m_rsp()) begin fails++; $display("FAIL bp_rsp: got %h want %h", {rsp_id, rsp_sum}, m_rsp()); end
      end
      if (k >= 3 && k < 8) begin
        if (k == 3) held = {rsp_id, rsp_sum};
        tests++;
        if (req_ready !== '0 || !rsp_valid || {rsp_id, rsp_sum} !== held) begin
          fails++; $display("FAIL bp_stall: ready=%b valid=%b rsp=%h want ready=0000 valid=1 rsp=%h", req_ready, rsp_valid, {rsp_id, rsp_sum}, held);
        end
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    drain();
    rsp_ready = 1'b0;
    vv[1:0] = 2'b11; vx[0] = 16'h0001; vy[0] = 16'h0002; vx[1] = 16'h0003; vy[1] = 16'h0004;
    for (int k = 0; k < 3; k++) begin @(negedge clk); step(); end
    rst = 1'b1; vv = '1;
    @(negedge clk);
    tests++;
    if (req_ready !== '0) begin fails++; $display("FAIL rmid_ready_in_rst: got %b want 0000", req_ready); end
    step();
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0001) begin
      fails++; $display("FAIL rmid_after: got valid=%b ready=%b want valid=0 ready=0001", rsp_valid, req_ready);
    end
    step();
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      tests++;
      if (rsp_valid !== m_vis()) begin fails++; $display("FAIL rmid_valid: got %b want %b", rsp_valid, m_vis()); end
      if (m_vis()) begin
        tests++;
        if ({rsp_id, rsp_sum} !== m_rsp()) begin fails++; $display("FAIL rmid_rsp: got %h want %h", {rsp_id, rsp_sum}, m_rsp()); end
      end
      step();
    end
  endtask

  task automatic test_lone();
    drain();
    vv[3] = 1'b1; vx[3] = 16'h8000; vy[3] = 16'h8001;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      tests++;
      if (req_ready !== 4'b1000) begin fails++; $display("FAIL lone_ready: got %b want 1000", req_ready); end
      tests++;
      if (rsp_valid !== (k >= 2)) begin fails++; $display("FAIL lone_valid: got %b want %b", rsp_valid, k >= 2); end
      if (m_vis()) begin
        tests++;
        if ({rsp_id, rsp_sum} !== m_rsp()) begin fails++; $display("FAIL lone_rsp: got %h want %h", {rsp_id, rsp_sum}, m_rsp()); end
      end
      step();
      vv[3] = 1'b1; vx[3] = 16'($urandom); vy[3] = 16'($urandom);
    end
    vv[3] = 1'b0;
  endtask

  task automatic test_random();
    drain();
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 49) == 0);
      rsp_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < N; i++)
        if (!vv[i] && $urandom_range(0, 1) == 1) begin vv[i] = 1'b1; vx[i] = 16'($urandom); vy[i] = 16'($urandom); end
      @(negedge clk);
      tests++;
      if (req_ready !== m_ready()) begin fails++; $display("FAIL rand_ready@%0d: got %b want %b", k, req_ready, m_ready()); end
      tests++;
      if (rsp_valid !== m_vis()) begin fails++; $display("FAIL rand_valid@%0d: got %b want %b", k, rsp_valid, m_vis()); end
      if (m_vis()) begin
        tests++;
        if ({rsp_id, rsp_sum} !== m_rsp()) begin fails++; $display("FAIL rand_rsp@%0d: got %h want %h", k, {rsp_id, rsp_sum}, m_rsp()); end
      end
      step();
    end
    rst = 1'b0;
  endtask

  initial begin
    tests = 0; fails = 0; rr = 0; cyc = 0;
    test_reset();
    test_single_add();
    test_carry();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    test_lone();
    test_random();
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end
endmodule
